irq_trap_ctrl: RTL
==================

// Module: irq_trap_ctrl
// PURPOSE
//  Sequences interrupt entry and mret return for the 5-stage RV32I core.
//  - Arbitrates level interrupt lines by fixed priority.
//  - Picks a safe cycle: slot valid, no stall.
//  - Drives pipeline flush, PC redirect and CSR trap/return strobes.
//  - Sits beside the hazard unit; its flush ORs into flush_ID/EX and its redirect overrides the branch PC mux.
// PARAMETERS
//  NUM_IRQ   4   number of interrupt request lines (1..16)
//  IRQ_BASE  16  mcause code of line 0; line k reports IRQ_BASE+k
//  HOLD_CYC  2   cycles new trap/mret is blocked after a redirect (1..7)
// PORTS
//  i_clk         in   1        core clock
//  i_reset       in   1        asynchronous, active-high reset
//  i_irq         in   NUM_IRQ  level interrupt requests
//  i_irq_en      in   NUM_IRQ  per-line enable (mie bits from CSR file)
//  i_mie         in   1        global enable (mstatus.MIE)
//  i_mtvec       in   32       trap vector base from CSR file
//  i_mepc        in   32       return address from CSR file
//  i_pc_ex       in   32       PC of instruction in EX (oldest uncommitted)
//  i_pc_ex_vld   in   1        EX holds a real instruction (not bubble)
//  i_mret_ex     in   1        instruction in EX is mret (decoded mret, piped)
//  i_stall       in   1        pipeline stall (load-use / memory wait)
//  o_flush       out  1        flush IF, ID, EX
//  o_pc_redir    out  1        select o_pc_target as next PC
//  o_pc_target   out  32       redirect address
//  o_trap_we     out  1        CSR: mepc<=o_mepc, mcause<=o_mcause, MPIE<=MIE, MIE<=0
//  o_mepc        out  32       saved PC for trap
//  o_mcause      out  32       {1'b1, 31'(IRQ_BASE+idx)}
//  o_mret_we     out  1        CSR: MIE<=MPIE, MPIE<=1
//  o_irq_ack     out  NUM_IRQ  one-hot acknowledge, 1 cycle
//  o_busy        out  1        state != IDLE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, hold counter=0, mepc/mcause regs=0; all outputs 0.
//  - pending = i_irq & i_irq_en. Winner = lowest set index (line 0 highest priority).
//  - Take condition: i_mie & |pending & i_pc_ex_vld & !i_stall.
//  - IDLE:
//    - take: latch winner idx, mepc<=i_pc_ex; -> TRAP.
//    - else if i_mret_ex & i_pc_ex_vld & !i_stall: -> MRET.
//    - Interrupt wins over simultaneous mret; that mret is flushed and refetched.
//    - Stall or bubble: stay IDLE, re-evaluate every cycle; no partial action.
//  - TRAP (exactly 1 cycle, ignores i_stall):
//    - o_flush=1, o_pc_redir=1, o_pc_target={i_mtvec[31:2],2'b00}.
//    - o_trap_we=1, o_mepc/o_mcause from latches, o_irq_ack=onehot(idx).
//    - -> HOLD, cnt<=HOLD_CYC-1.
//  - MRET (1 cycle): o_flush=1, o_pc_redir=1, o_pc_target=i_mepc, o_mret_we=1; -> HOLD.
//  - HOLD: all strobes 0; cnt decrements; at cnt==0 -> IDLE. Inputs ignored.
//  - Latency: qualifying request sampled at edge N -> TRAP outputs valid in cycle N+1 (Moore, registered state).
//  - Line dropping after latch is still serviced with the latched idx. Handler must clear the source; MIE=0 after trap blocks re-entry.
//  - o_mcause uses 31-bit add; IRQ_BASE+NUM_IRQ-1 must be < 2^31.
//  - Non-TRAP/MRET states: o_pc_target, o_mepc, o_mcause = 0.
// STRUCTURE
//  - irq_pkg: state enum {IDLE,TRAP,MRET,HOLD}; MCAUSE_INT_BIT; default IRQ_BASE.
//  - Sub-module irq_prio_enc #(NUM_IRQ): pending -> {any, idx}, combinational.
//  - Body: FSM + hold counter + mepc/idx latches.
// TESTING
//  1. irq=4'b0110, en=4'hF, mie=1, pc_ex=0x0000_0040 vld -> next cycle flush, redir, target=mtvec&~3, mepc=0x40, mcause=0x8000_0011, ack=4'b0010.
//  2. Same irq with i_stall=1 for 3 cycles -> no strobes while stalled; TRAP 1 cycle after stall drops.
//  3. i_mret_ex=1, mepc=0x0000_0044 -> redir target=0x44, o_mret_we=1 one cycle; o_busy for 1+HOLD_CYC cycles.
//  4. irq line 3 plus mret same cycle, mie=1 -> TRAP taken, mepc=pc of mret, o_mret_we stays 0.
//  5. mie=0 or en=0 or pc_ex_vld=0 with irq active -> no outputs, state stays IDLE.
//  6. Assert i_reset during HOLD and during TRAP -> outputs 0 immediately; IDLE after release, no ack.

Source files
------------

// File: rtl/irq_trap_ctrl_pkg.sv
// irq_trap_ctrl_pkg: shared state encoding and constants for the interrupt/trap sequencer.
package irq_trap_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, TRAP, MRET, HOLD} state_e;
    localparam logic [31:0] MCAUSE_INT_BIT = 32'h8000_0000;
    localparam int DEF_IRQ_BASE = 16;
endpackage

// File: rtl/irq_trap_ctrl_if.sv
// irq_trap_ctrl_if: pipeline/CSR-side signals of the interrupt/trap sequencer.
interface irq_trap_ctrl_if #(parameter int NUM_IRQ = 4);
    logic [NUM_IRQ-1:0] irq_i;
    logic [NUM_IRQ-1:0] irq_en_i;
    logic               mie_i;
    logic [31:0]        mtvec_i;
    logic [31:0]        mepc_i;
    logic [31:0]        pc_ex_i;
    logic               pc_ex_vld_i;
    logic               mret_ex_i;
    logic               stall_i;
    logic               flush_o;
    logic               pc_redir_o;
    logic [31:0]        pc_target_o;
    logic               trap_we_o;
    logic [31:0]        mepc_o;
    logic [31:0]        mcause_o;
    logic               mret_we_o;
    logic [NUM_IRQ-1:0] irq_ack_o;
    logic               busy_o;
    modport master (
        output irq_i, irq_en_i, mie_i, mtvec_i, mepc_i, pc_ex_i, pc_ex_vld_i, mret_ex_i, stall_i,
        input  flush_o, pc_redir_o, pc_target_o, trap_we_o, mepc_o, mcause_o, mret_we_o, irq_ack_o, busy_o
    );
    modport slave (
        input  irq_i, irq_en_i, mie_i, mtvec_i, mepc_i, pc_ex_i, pc_ex_vld_i, mret_ex_i, stall_i,
        output flush_o, pc_redir_o, pc_target_o, trap_we_o, mepc_o, mcause_o, mret_we_o, irq_ack_o, busy_o
    );
endinterface

// File: rtl/irq_trap_ctrl_prio_enc.sv
// irq_prio_enc: fixed-priority encoder, lowest set index wins.
module irq_prio_enc #(
    parameter int NUM_IRQ = 4,
    parameter int IW = 2
) (
    input  logic [NUM_IRQ-1:0] pending_i,
    output logic               any_o,
    output logic [IW-1:0]      idx_o
);
    always_comb begin
        any_o = |pending_i;
        idx_o = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--)
            if (pending_i[k]) idx_o = IW'(k);
    end
endmodule

// File: rtl/irq_trap_ctrl.sv
// irq_trap_ctrl: sequences interrupt entry and mret return (flush, redirect, CSR strobes).
module irq_trap_ctrl
    import irq_trap_ctrl_pkg::*;
#(
    parameter int NUM_IRQ  = 4,
    parameter int IRQ_BASE = DEF_IRQ_BASE,
    parameter int HOLD_CYC = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    irq_trap_ctrl_if.slave  bus
);
    localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;

    state_e        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d, win_idx;
    logic [31:0]   mepc_q, mepc_d;
    logic          any, take, mret_go, is_trap, is_mret;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ), .IW(IW)) u_enc (
        .pending_i (bus.irq_i & bus.irq_en_i),
        .any_o     (any),
        .idx_o     (win_idx)
    );

    assign take    = bus.mie_i & any & bus.pc_ex_vld_i & ~bus.stall_i;
    assign mret_go = bus.mret_ex_i & bus.pc_ex_vld_i & ~bus.stall_i;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            mepc_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            mepc_q  <= mepc_d;
        end
    end

    // Interrupt outranks a coincident mret; the mret is flushed and refetched later.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        mepc_d  = mepc_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = TRAP;
                    idx_d   = win_idx;
                    mepc_d  = bus.pc_ex_i;
                end else if (mret_go) begin
                    state_d = MRET;
                end
            end
            TRAP, MRET: begin
                state_d = HOLD;
                cnt_d   = 3'(HOLD_CYC - 1);
            end
            default: begin
                state_d = cnt_q == '0 ? IDLE : HOLD;
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 3'd1;
            end
        endcase
    end

    assign is_trap         = state_q == TRAP;
    assign is_mret         = state_q == MRET;
    assign bus.flush_o     = is_trap | is_mret;
    assign bus.pc_redir_o  = is_trap | is_mret;
    assign bus.pc_target_o = is_trap ? {bus.mtvec_i[31:2], 2'b00} : is_mret ? bus.mepc_i : '0;
    assign bus.trap_we_o   = is_trap;
    assign bus.mret_we_o   = is_mret;
    assign bus.mepc_o      = is_trap ? mepc_q : '0;
    assign bus.mcause_o    = is_trap ? (MCAUSE_INT_BIT | {1'b0, 31'(IRQ_BASE) + 31'(idx_q)}) : '0;
    assign bus.irq_ack_o   = is_trap ? NUM_IRQ'(1) << idx_q : '0;
    assign bus.busy_o      = state_q != IDLE;
endmodule
